vx_wctl_seq_unit: RTL
=====================

// Module: vx_wctl_seq_unit
// PURPOSE
//  Next-generation warp-control execute stage. Accepts SFU warp-control ops as one or more
//  lane-group beats (pid) per instruction and accumulates per-warp then/else masks across beats.
//  Emits one registered warp-control command per instruction with valid/ready backpressure,
//  plus one buffered writeback response per beat. Sits between SFU dispatch and the scheduler.
// PARAMETERS
//  NUM_THREADS  8   threads per warp
//  NUM_LANES    4   lanes per beat; NUM_THREADS % NUM_LANES == 0
//  NUM_WARPS    4   warps per core; sizes the accumulation table
//  RSP_DEPTH    2   response FIFO entries, >= 2
//  PERF_W       32  perf counter width (perf build only)
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-low (0 = reset)
//  in_valid/ready in/out 1               beat handshake
//  in_wid         in   NW_WIDTH          warp id
//  in_op          in   3                 wctl_op_e: TMC=0 WSPAWN=1 SPLIT=2 JOIN=3 BAR=4 PRED=5
//  in_is_neg      in   1                 invert predicate
//  in_tmask       in   NUM_LANES         active lanes of this beat
//  in_pid         in   PID_WIDTH         beat index
//  in_sop/in_eop  in   1                 first / last beat of instruction
//  in_rs1/in_rs2  in   NUM_LANES*XLEN    operands per lane
//  in_pc          in   PC_BITS           instruction PC
//  ctl_valid/ready out/in 1              command handshake
//  ctl_wid/ctl_op out  NW_WIDTH/3        target warp, op
//  ctl_then/else  out  NUM_THREADS each  ordered masks (taken first)
//  ctl_is_dvg     out  1                 both masks non-zero
//  ctl_arg0/arg1  out  XLEN each         rs1/rs2 of highest active lane in the instruction
//  ctl_next_pc    out  PC_BITS           in_pc + 4
//  rsp_valid/ready out/in 1              per-beat writeback handshake
//  rsp_wid/tmask/pid/sop/eop out         echo of accepted beat
// BEHAVIOUR
//  - Reset: ctl_valid=0, rsp_valid=0, FIFO empty, perf counters 0; table contents don't-care.
//  - Beat accepted when in_valid && in_ready.
//    in_ready = !fifo_full && (!in_eop || !ctl_valid || ctl_ready).
//  - taken[i] = in_rs1[i][0] ^ in_is_neg.
//  - Table row wid holds {else,then,arg0,arg1}. On sop, row is cleared before merge.
//    Bits [pid*NUM_LANES +: NUM_LANES] take taken&tmask / ~taken&tmask; other bits keep value.
//  - Args are overwritten only when the beat has any active lane. They take the highest active lane.
//  - Beats of different warps may interleave; beats of one warp arrive in pid order.
//  - On eop, command is built from merged masks (bypassing the table write) and registered.
//    ctl_valid rises the next cycle and holds, stable, until ctl_ready.
//  - Same-cycle ctl_ready and a new eop accept: slot drains and refills; no bubble.
//  - SPLIT: then_first = popcnt(then) >= popcnt(else); ctl_then/else swap when !then_first.
//    Ties keep then first.
//  - PRED: ctl_then = then!=0 ? then : arg1[NUM_THREADS-1:0]. TMC: ctl_then = arg0[NUM_THREADS-1:0].
//  - Other ops pass masks and args unchanged; scheduler decodes.
//  - Response: each accepted beat is pushed to the FIFO. Latency >= 1 cycle, FIFO order.
//  - All-zero tmask beat: contributes nothing, still produces a response.
//  - Reset mid-instruction discards partial state; next beat must carry sop.
//  - Assertion: in_pid < NUM_THREADS/NUM_LANES. Assertion: no eop before sop for a warp after reset.
// CONFIGURATION
//  VX_WCTL_PERF_EN defined: adds outputs perf_splits, perf_dvg (PERF_W each).
//    perf_splits increments on each SPLIT command accept; perf_dvg increments only when is_dvg=1.
//    Both counters saturate.
//  VX_WCTL_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  VX_gpu_pkg: wctl_op_e, wctl_cmd_t (wid, op, then, else, is_dvg, arg0, arg1, next_pc).
//  Sub-module vx_wctl_mask_acc: per-warp table, sop clear, pid-slice merge, arg capture.
//  Reuse VX_fifo_queue for the response FIFO and the existing popcount macro.
// TESTING  (NUM_THREADS=8, NUM_LANES=4)
//  1 SPLIT w1: pid0 sop tmask=F rs1[0]=1,0,1,0; pid1 eop tmask=3 rs1[0]=1,1
//    -> then=0x35 else=0x0A is_dvg=1.
//  2 SPLIT single sop+eop pid0 tmask=F rs1[0]=1,0,0,0 -> swapped: ctl_then=0x0E ctl_else=0x01.
//  3 PRED, all lanes not taken, rs2=0xF0 on highest lane -> ctl_then=0xF0.
//  4 ctl_ready=0 with pending cmd: next eop beat sees in_ready=0; non-eop beat of w2 is accepted.
//    Release -> commands appear in order.
//  5 reset low after pid0 of w1, then sop pid0 tmask=0 + eop pid1 tmask=1 rs1=1 -> then=0x10.
//  6 interleave w0/w2 two-beat SPLITs; rsp_ready toggled -> masks independent, responses in order.

Source files
------------

// File: rtl/vx_wctl_seq_unit_pkg.sv
// Shared types, sizes and helpers for the warp-control execute stage.
// Optional perf counters in vx_wctl_seq_unit are enabled by defining VX_WCTL_PERF_EN.
package vx_wctl_seq_unit_pkg;

  localparam int unsigned NUM_THREADS = 8;
  localparam int unsigned NUM_LANES   = 4;
  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned RSP_DEPTH   = 2;
  localparam int unsigned PERF_W      = 32;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned PC_BITS     = 32;

  localparam int unsigned NUM_PIDS  = NUM_THREADS / NUM_LANES;
  localparam int unsigned NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned PID_WIDTH = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam int unsigned POPCNT_W  = $clog2(NUM_THREADS + 1);

  typedef enum logic [2:0] {
    OP_TMC    = 3'd0,
    OP_WSPAWN = 3'd1,
    OP_SPLIT  = 3'd2,
    OP_JOIN   = 3'd3,
    OP_BAR    = 3'd4,
    OP_PRED   = 3'd5
  } wctl_op_e;

  typedef struct packed {
    logic [NW_WIDTH-1:0]    wid;
    wctl_op_e               op;
    logic [NUM_THREADS-1:0] then_mask;
    logic [NUM_THREADS-1:0] else_mask;
    logic                   is_dvg;
    logic [XLEN-1:0]        arg0;
    logic [XLEN-1:0]        arg1;
    logic [PC_BITS-1:0]     next_pc;
  } wctl_cmd_t;

  typedef struct packed {
    logic [NW_WIDTH-1:0]  wid;
    logic [NUM_LANES-1:0] tmask;
    logic [PID_WIDTH-1:0] pid;
    logic                 sop;
    logic                 eop;
  } wctl_rsp_t;

  function automatic logic [POPCNT_W-1:0] popcnt(input logic [NUM_THREADS-1:0] m);
    logic [POPCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      c = c + POPCNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vx_wctl_seq_unit_mask_acc.sv
// Per-warp then/else mask and argument accumulator across lane-group beats.
// Produces the merged view of the current beat combinationally and stores it on accept.
module vx_wctl_seq_unit_mask_acc
  import vx_wctl_seq_unit_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      we_i,
  input  logic [NW_WIDTH-1:0]       wid_i,
  input  logic [PID_WIDTH-1:0]      pid_i,
  input  logic                      sop_i,
  input  logic                      eop_i,
  input  logic [NUM_LANES-1:0]      tmask_i,
  input  logic [NUM_LANES-1:0]      taken_i,
  input  logic [NUM_LANES*XLEN-1:0] rs1_i,
  input  logic [NUM_LANES*XLEN-1:0] rs2_i,
  output logic [NUM_THREADS-1:0]    then_c_o,
  output logic [NUM_THREADS-1:0]    else_c_o,
  output logic [XLEN-1:0]           arg0_c_o,
  output logic [XLEN-1:0]           arg1_c_o
);

  logic [NUM_THREADS-1:0] then_q [NUM_WARPS];
  logic [NUM_THREADS-1:0] else_q [NUM_WARPS];
  logic [XLEN-1:0]        arg0_q [NUM_WARPS];
  logic [XLEN-1:0]        arg1_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]   open_q;

  // sop starts from an empty row; only this beat's pid slice is replaced
  always_comb begin
    then_c_o = sop_i ? '0 : then_q[wid_i];
    else_c_o = sop_i ? '0 : else_q[wid_i];
    arg0_c_o = sop_i ? '0 : arg0_q[wid_i];
    arg1_c_o = sop_i ? '0 : arg1_q[wid_i];
    for (int p = 0; p < NUM_PIDS; p++) begin
      if (pid_i == PID_WIDTH'(p)) begin
        then_c_o[p*NUM_LANES +: NUM_LANES] = taken_i & tmask_i;
        else_c_o[p*NUM_LANES +: NUM_LANES] = ~taken_i & tmask_i;
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (tmask_i[l]) begin
        arg0_c_o = rs1_i[l*XLEN +: XLEN];
        arg1_c_o = rs2_i[l*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      then_q[wid_i] <= then_c_o;
      else_q[wid_i] <= else_c_o;
      arg0_q[wid_i] <= arg0_c_o;
      arg1_q[wid_i] <= arg1_c_o;
    end
  end

  // Tracks warps with an instruction in flight so a stray continuation beat is caught
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      open_q <= '0;
    end else if (we_i) begin
      if (eop_i) begin
        open_q[wid_i] <= 1'b0;
      end else if (sop_i) begin
        open_q[wid_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i && we_i) begin
      assert (32'(pid_i) < NUM_PIDS);
      assert (!(eop_i && !sop_i && !open_q[wid_i]));
    end
  end

endmodule

// File: rtl/vx_wctl_seq_unit.sv
// Warp-control execute stage: accumulates beats, emits one registered command per
// instruction and one FIFO-buffered response per beat. Define VX_WCTL_PERF_EN for perf counters.
module vx_wctl_seq_unit
  import vx_wctl_seq_unit_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NW_WIDTH-1:0]       in_wid_i,
  input  logic [2:0]                in_op_i,
  input  logic                      in_is_neg_i,
  input  logic [NUM_LANES-1:0]      in_tmask_i,
  input  logic [PID_WIDTH-1:0]      in_pid_i,
  input  logic                      in_sop_i,
  input  logic                      in_eop_i,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1_i,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2_i,
  input  logic [PC_BITS-1:0]        in_pc_i,
  output logic                      ctl_valid_o,
  input  logic                      ctl_ready_i,
  output logic [NW_WIDTH-1:0]       ctl_wid_o,
  output logic [2:0]                ctl_op_o,
  output logic [NUM_THREADS-1:0]    ctl_then_o,
  output logic [NUM_THREADS-1:0]    ctl_else_o,
  output logic                      ctl_is_dvg_o,
  output logic [XLEN-1:0]           ctl_arg0_o,
  output logic [XLEN-1:0]           ctl_arg1_o,
  output logic [PC_BITS-1:0]        ctl_next_pc_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [NW_WIDTH-1:0]       rsp_wid_o,
  output logic [NUM_LANES-1:0]      rsp_tmask_o,
  output logic [PID_WIDTH-1:0]      rsp_pid_o,
  output logic                      rsp_sop_o,
  output logic                      rsp_eop_o
`ifdef VX_WCTL_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_splits_o,
  output logic [PERF_W-1:0]         perf_dvg_o
`endif
);

  localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned RCNT_W = $clog2(RSP_DEPTH + 1);

  logic                   in_fire;
  logic                   cmd_fire;
  logic                   ctl_fire;
  logic                   fifo_full;
  logic                   rsp_pop;
  logic [NUM_LANES-1:0]   taken;
  logic [NUM_THREADS-1:0] acc_then;
  logic [NUM_THREADS-1:0] acc_else;
  logic [XLEN-1:0]        acc_arg0;
  logic [XLEN-1:0]        acc_arg1;
  wctl_op_e               op;
  wctl_cmd_t              cmd_d;
  wctl_cmd_t              cmd_q;
  logic                   ctl_valid_d;
  logic                   ctl_valid_q;

  wctl_rsp_t              rsp_mem_q [RSP_DEPTH];
  wctl_rsp_t              rsp_head;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [RCNT_W-1:0]      rsp_cnt_q;

  // An eop beat may only enter when the command slot is free or draining this cycle
  assign in_ready_o = !fifo_full && (!in_eop_i || !ctl_valid_q || ctl_ready_i);
  assign in_fire    = in_valid_i && in_ready_o;
  assign cmd_fire   = in_fire && in_eop_i;
  assign ctl_fire   = ctl_valid_q && ctl_ready_i;
  assign op         = wctl_op_e'(in_op_i);

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      taken[l] = in_rs1_i[l*XLEN] ^ in_is_neg_i;
    end
  end

  vx_wctl_seq_unit_mask_acc u_mask_acc (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .we_i     (in_fire),
    .wid_i    (in_wid_i),
    .pid_i    (in_pid_i),
    .sop_i    (in_sop_i),
    .eop_i    (in_eop_i),
    .tmask_i  (in_tmask_i),
    .taken_i  (taken),
    .rs1_i    (in_rs1_i),
    .rs2_i    (in_rs2_i),
    .then_c_o (acc_then),
    .else_c_o (acc_else),
    .arg0_c_o (acc_arg0),
    .arg1_c_o (acc_arg1)
  );

  // Command build from the merged masks of the final beat
  always_comb begin
    cmd_d           = '0;
    cmd_d.wid       = in_wid_i;
    cmd_d.op        = op;
    cmd_d.then_mask = acc_then;
    cmd_d.else_mask = acc_else;
    cmd_d.arg0      = acc_arg0;
    cmd_d.arg1      = acc_arg1;
    cmd_d.next_pc   = in_pc_i + PC_BITS'(4);
    case (op)
      OP_SPLIT: begin
        if (popcnt(acc_then) < popcnt(acc_else)) begin
          cmd_d.then_mask = acc_else;
          cmd_d.else_mask = acc_then;
        end
      end
      OP_PRED: begin
        if (acc_then == '0) begin
          cmd_d.then_mask = acc_arg1[NUM_THREADS-1:0];
        end
      end
      OP_TMC:  cmd_d.then_mask = acc_arg0[NUM_THREADS-1:0];
      default: ;
    endcase
    cmd_d.is_dvg = (|cmd_d.then_mask) && (|cmd_d.else_mask);
  end

  always_comb begin
    ctl_valid_d = ctl_valid_q;
    if (cmd_fire) begin
      ctl_valid_d = 1'b1;
    end else if (ctl_fire) begin
      ctl_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ctl_valid_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      ctl_valid_q <= ctl_valid_d;
      if (cmd_fire) begin
        cmd_q <= cmd_d;
      end
    end
  end

  assign ctl_valid_o   = ctl_valid_q;
  assign ctl_wid_o     = cmd_q.wid;
  assign ctl_op_o      = cmd_q.op;
  assign ctl_then_o    = cmd_q.then_mask;
  assign ctl_else_o    = cmd_q.else_mask;
  assign ctl_is_dvg_o  = cmd_q.is_dvg;
  assign ctl_arg0_o    = cmd_q.arg0;
  assign ctl_arg1_o    = cmd_q.arg1;
  assign ctl_next_pc_o = cmd_q.next_pc;

  // Response FIFO: one entry per accepted beat, read from registered storage
  assign fifo_full   = (rsp_cnt_q == RCNT_W'(RSP_DEPTH));
  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (in_fire) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (rsp_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (in_fire && !rsp_pop) begin
        rsp_cnt_q <= rsp_cnt_q + RCNT_W'(1);
      end else if (!in_fire && rsp_pop) begin
        rsp_cnt_q <= rsp_cnt_q - RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      rsp_mem_q[wr_ptr_q] <= '{wid: in_wid_i, tmask: in_tmask_i, pid: in_pid_i,
                               sop: in_sop_i, eop: in_eop_i};
    end
  end

  assign rsp_head    = rsp_mem_q[rd_ptr_q];
  assign rsp_wid_o   = rsp_head.wid;
  assign rsp_tmask_o = rsp_head.tmask;
  assign rsp_pid_o   = rsp_head.pid;
  assign rsp_sop_o   = rsp_head.sop;
  assign rsp_eop_o   = rsp_head.eop;

`ifdef VX_WCTL_PERF_EN
  logic              split_acc;
  logic [PERF_W-1:0] perf_splits_q;
  logic [PERF_W-1:0] perf_dvg_q;

  // Counted when the scheduler takes a SPLIT; both counters stick at all-ones
  assign split_acc = ctl_fire && (cmd_q.op == OP_SPLIT);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      perf_splits_q <= '0;
      perf_dvg_q    <= '0;
    end else begin
      if (split_acc && !(&perf_splits_q)) begin
        perf_splits_q <= perf_splits_q + PERF_W'(1);
      end
      if (split_acc && cmd_q.is_dvg && !(&perf_dvg_q)) begin
        perf_dvg_q <= perf_dvg_q + PERF_W'(1);
      end
    end
  end

  assign perf_splits_o = perf_splits_q;
  assign perf_dvg_o    = perf_dvg_q;
`endif

endmodule
